map_column_streamer: RTL

- Upstream feeder for the game datapath's PHYSICS shift step. Replaces the hard-coded next-wall pattern with columns read from a narrow map ROM.
- Reads WORDS_PER_COL ROM words per column and assembles each 100-bit vwall column plus its hwall bit.
- Buffers assembled columns in a 2-entry FIFO and hands them to the datapath with a valid/request handshake.
- Reports end-of-map so the datapath can raise endgame.

---
 rtl/map_column_streamer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/map_column_streamer.sv
// -----------------------------------------------------------------------------
// map_column_streamer
//
// Upstream feeder for the PHYSICS shift step. Streams vwall columns out of a
// narrow map ROM: WORDS_PER_COL consecutive ROM words are assembled into one
// COL_BITS-wide column (word 0 in the low bits). Each column is pushed into a
// 2-entry FIFO together with its hwall bit (OR of the column), its map column
// number, and a flag marking the last map column. The datapath pops one
// column per PHYSICS step with col_req.
//
// Ports
//   clk        system clock (game tick domain)
//   resetn     asynchronous active-low reset
//   restart    synchronous clear/rewind (held high while in MENU)
//   col_req    pop request, one-cycle pulse per PHYSICS step
//   col_valid  FIFO head holds a column
//   col_data   FIFO head column, bit j = row j (0 while empty)
//   col_hwall  OR-reduce of col_data, registered with the entry
//   col_index  low 8 bits of the map column number of the FIFO head
//   map_done   sticky: last map column consumed (LOOP=0 only)
//   underflow  sticky: col_req arrived while col_valid=0
//   rom_rd     ROM read strobe
//   rom_addr   ROM word address
//   rom_q      ROM data, valid exactly one cycle after rom_rd
// -----------------------------------------------------------------------------
module map_column_streamer #(
  parameter int COL_BITS      = 100,
  parameter int WORD_BITS     = 20,
  parameter int WORDS_PER_COL = 5,
  parameter int MAP_COLS      = 256,
  parameter int ADDR_W        = 11,
  parameter int LOOP          = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 restart,
  input  logic                 col_req,
  output logic                 col_valid,
  output logic [COL_BITS-1:0]  col_data,
  output logic                 col_hwall,
  output logic [7:0]           col_index,
  output logic                 map_done,
  output logic                 underflow,
  output logic                 rom_rd,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [WORD_BITS-1:0] rom_q
);

  localparam int CNT_W = ($clog2(MAP_COLS) > 8) ? $clog2(MAP_COLS) : 8;
  localparam int WRD_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;

  typedef enum logic [1:0] {FETCH, DRAIN, WAIT, STOP} state_t;

  state_t              state_q, state_d;
  logic [WRD_W-1:0]    word_q, word_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic                last_col;

  logic                cap_vld_p1;
  logic [WRD_W-1:0]    cap_w_p1;
  logic [COL_BITS-1:0] asm_q, asm_d;

  logic [1:0]          cnt_q, cnt_after;
  logic                push, pop;
  logic                head_last;
  logic [COL_BITS-1:0] slot1_data;
  logic                slot1_hwall;
  logic [7:0]          slot1_idx;
  logic                slot1_last;
  logic                ld0_new, ld0_shift, ld0_clr, ld1_new;

  // ---------------------------------------------------------------------------
  // Stage p0: ROM request. The strobe is gated by resetn so it reads 0 while
  // reset is held even though the FSM already sits in FETCH, and by restart
  // so a rewind cycle issues no read.
  // ---------------------------------------------------------------------------
  assign rom_rd   = resetn && !restart && (state_q == FETCH);
  assign rom_addr = ADDR_W'(col_q) * ADDR_W'(WORDS_PER_COL) + ADDR_W'(word_q);
  assign last_col = (col_q == CNT_W'(MAP_COLS - 1));

  assign col_valid = (cnt_q != 2'd0);
  assign push      = (state_q == DRAIN) && !restart;
  assign pop       = col_req && col_valid && !restart;
  assign cnt_after = cnt_q + {1'b0, push} - {1'b0, pop};

  // ---------------------------------------------------------------------------
  // Stage p1: ROM data returns; merge it into the assembly word it was issued
  // for. In DRAIN asm_d already holds the complete column, so it is pushed
  // straight from here.
  // ---------------------------------------------------------------------------
  always_comb begin
    asm_d = asm_q;
    if (cap_vld_p1) begin
      asm_d[int'(cap_w_p1) * WORD_BITS +: WORD_BITS] = rom_q;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    col_d   = col_q;
    case (state_q)
      FETCH: begin
        if (word_q == WRD_W'(WORDS_PER_COL - 1)) begin
          state_d = DRAIN;
          word_d  = '0;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      DRAIN: begin
        col_d = last_col ? '0 : col_q + 1'b1;
        if (last_col && (LOOP == 0)) begin
          state_d = STOP;
        end else if (cnt_after == 2'd2) begin
          state_d = WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (pop) begin
          state_d = FETCH;
        end
      end
      STOP: begin
        state_d = STOP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FETCH;
      word_q     <= '0;
      col_q      <= '0;
      cap_vld_p1 <= 1'b0;
      cnt_q      <= 2'd0;
      map_done   <= 1'b0;
      underflow  <= 1'b0;
    end else if (restart) begin
      state_q    <= FETCH;
      word_q     <= '0;
      col_q      <= '0;
      cap_vld_p1 <= 1'b0;
      cnt_q      <= 2'd0;
      map_done   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      col_q      <= col_d;
      cap_vld_p1 <= rom_rd;
      cnt_q      <= cnt_after;
      if (pop && head_last && (LOOP == 0)) begin
        map_done <= 1'b1;
      end
      if (col_req && !col_valid) begin
        underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cap_w_p1 <= word_q;
    asm_q    <= asm_d;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: 2-entry FIFO. Slot 0 is the head and drives the outputs
  // directly; it is cleared when it empties so col_data reads 0 while invalid.
  // A push only ever happens with at most one entry held.
  // ---------------------------------------------------------------------------
  assign ld0_new   = push && ((cnt_q == 2'd0) || (pop && (cnt_q == 2'd1)));
  assign ld0_shift = pop && (cnt_q == 2'd2);
  assign ld0_clr   = pop && !push && (cnt_q == 2'd1);
  assign ld1_new   = push && ((!pop && (cnt_q == 2'd1)) || (pop && (cnt_q == 2'd2)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_data  <= '0;
      col_hwall <= 1'b0;
      col_index <= 8'd0;
      head_last <= 1'b0;
    end else if (restart || ld0_clr) begin
      col_data  <= '0;
      col_hwall <= 1'b0;
      col_index <= 8'd0;
      head_last <= 1'b0;
    end else if (ld0_new) begin
      col_data  <= asm_d;
      col_hwall <= |asm_d;
      col_index <= col_q[7:0];
      head_last <= last_col;
    end else if (ld0_shift) begin
      col_data  <= slot1_data;
      col_hwall <= slot1_hwall;
      col_index <= slot1_idx;
      head_last <= slot1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1_new) begin
      slot1_data  <= asm_d;
      slot1_hwall <= |asm_d;
      slot1_idx   <= col_q[7:0];
      slot1_last  <= last_col;
    end
  end

endmodule
